// File: rtl/load_store_unit.sv
// Data-memory access stage: request/grant/response port, store lane formatting, load extension.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned half/word accesses into an error completion.
module load_store_unit #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned XLEN   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              req_ready,
   output logic              stall,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              misalign,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state, state_next;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN-1:0]   rdata_q;
   logic              accept;
   logic              req_mis;
   logic              is_byte, is_half;
   logic [3:0]        strb;
   logic [XLEN-1:0]   wdata_fmt;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [XLEN-1:0]   load_ext;

   assign accept = (state == IDLE) && req_valid;

   // funct3[1:0]: 00 byte, 01 half, 1x word; bit 2 only selects zero-extension for loads
`ifdef LSU_MISALIGN_TRAP_EN
   logic mis_q;

   assign req_mis  = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                   || (req_funct3[1] && (req_addr[1:0] != 2'b00));
   assign misalign = (state == DONE) && mis_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       mis_q <= 1'b0;
      else if (accept) mis_q <= req_mis;
   end
`else
   assign req_mis  = 1'b0;
   assign misalign = 1'b0;
`endif

   assign is_byte    = (funct3_q[1:0] == 2'b00);
   assign is_half    = (funct3_q[1:0] == 2'b01);
   assign resp_rdata = rdata_q;

   always_comb begin
      strb      = 4'b1111;
      wdata_fmt = wdata_q;
      if (is_byte) begin
         strb      = 4'b0001 << addr_q[1:0];
         wdata_fmt = {4{wdata_q[7:0]}};
      end else if (is_half) begin
         strb      = addr_q[1] ? 4'b1100 : 4'b0011;
         wdata_fmt = {2{wdata_q[15:0]}};
      end
   end

   always_comb begin
      case (addr_q[1:0])
         2'b00:   byte_sel = mem_rdata[7:0];
         2'b01:   byte_sel = mem_rdata[15:8];
         2'b10:   byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
      half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      if (is_byte)
         load_ext = {{24{byte_sel[7] & ~funct3_q[2]}}, byte_sel};
      else if (is_half)
         load_ext = {{16{half_sel[15] & ~funct3_q[2]}}, half_sel};
      else
         load_ext = mem_rdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         we_q     <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
         end
         // store and error completions report zero; loads report the extended word
         if ((accept && req_mis) || ((state == REQ) && mem_gnt && we_q))
            rdata_q <= '0;
         else if ((state == WAIT) && mem_rvalid)
            rdata_q <= load_ext;
      end
   end

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      stall      = 1'b0;
      resp_valid = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wstrb  = '0;
      mem_wdata  = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               stall      = 1'b1;
               state_next = req_mis ? DONE : REQ;
            end
         end
         REQ: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_we   = we_q;
            mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
            if (we_q) begin
               mem_wstrb = strb;
               mem_wdata = wdata_fmt;
            end
            if (mem_gnt) state_next = we_q ? DONE : WAIT;
         end
         WAIT: begin
            stall = 1'b1;
            if (mem_rvalid) state_next = DONE;
         end
         DONE: begin
            resp_valid = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // IDLE term would otherwise follow req_valid while reset is held
      if (reset) stall = 1'b0;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed spec cases plus randomized transactions
// compared every cycle against a transaction-level model.
module tb_load_store_unit;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned XLEN   = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_we = 1'b0;
   logic [2:0]        req_funct3 = '0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [XLEN-1:0]   req_wdata = '0;
   logic              req_ready, stall, resp_valid, misalign;
   logic [XLEN-1:0]   resp_rdata;
   logic              mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_wstrb;
   logic [XLEN-1:0]   mem_wdata;
   logic              mem_gnt = 1'b0;
   logic              mem_rvalid = 1'b0;
   logic [XLEN-1:0]   mem_rdata = '0;

   load_store_unit #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .stall(stall), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .misalign(misalign),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int   tests = 0;
   int   fails = 0;
   bit   chk_en = 1'b0;
   int   req_cycles = 0;

   logic        e_ready, e_stall, e_rv, e_mis, e_mreq, e_mwe;
   logic [15:0] e_maddr;
   logic [3:0]  e_strb;
   logic [31:0] e_mwdata, e_rdata;
   logic [31:0] hold_rdata = '0;

   logic [31:0] snap_rdata, snap_wdata;
   logic [15:0] snap_addr;
   logic [3:0]  snap_strb;
   logic        snap_mis;
   logic [31:0] g_rdata, g_wdata;
   logic [15:0] g_addr;
   logic [3:0]  g_strb;
   logic        g_mis;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int unsigned size_of(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         default:    return 4;
      endcase
   endfunction

   function automatic bit is_mis(input logic [2:0] f3, input logic [15:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
      return (size_of(f3) == 2 && addr[0]) || (size_of(f3) == 4 && addr[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [15:0] addr);
      int unsigned off = int'(addr[1:0]);
      case (size_of(f3))
         1:       return 4'(1 << off);
         2:       return (off >= 2) ? 4'hC : 4'h3;
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
      case (size_of(f3))
         1:       return (w & 32'hFF) * 32'h0101_0101;
         2:       return (w & 32'hFFFF) * 32'h0001_0001;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [15:0] addr,
                                              input logic [31:0] d);
      logic [31:0] v;
      int unsigned off = int'(addr[1:0]);
      case (size_of(f3))
         1: begin
            v = (d >> (8 * off)) & 32'hFF;
            if (f3[2] == 1'b0 && v >= 32'd128) v = v - 32'd256;
         end
         2: begin
            v = (d >> (16 * (off / 2))) & 32'hFFFF;
            if (f3[2] == 1'b0 && v >= 32'd32768) v = v - 32'd65536;
         end
         default: v = d;
      endcase
      return v;
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready",  32'(req_ready),  32'(e_ready));
         chk("stall",      32'(stall),      32'(e_stall));
         chk("resp_valid", 32'(resp_valid), 32'(e_rv));
         chk("misalign",   32'(misalign),   32'(e_mis));
         chk("resp_rdata", resp_rdata,      e_rdata);
         chk("mem_req",    32'(mem_req),    32'(e_mreq));
         chk("mem_we",     32'(mem_we),     32'(e_mwe));
         chk("mem_addr",   32'(mem_addr),   32'(e_maddr));
         chk("mem_wstrb",  32'(mem_wstrb),  32'(e_strb));
         chk("mem_wdata",  mem_wdata,       e_mwdata);
      end
      if (!reset && mem_req) req_cycles++;
   end

   task automatic exp_cycle(input logic rdy, input logic st, input logic rv, input logic mis,
                            input logic mreq, input logic mwe, input logic [15:0] ma,
                            input logic [3:0] sb, input logic [31:0] wd, input logic [31:0] rd);
      e_ready = rdy; e_stall = st; e_rv = rv; e_mis = mis; e_mreq = mreq; e_mwe = mwe;
      e_maddr = ma; e_strb = sb; e_mwdata = wd; e_rdata = rd;
   endtask

   task automatic tick();
      @(negedge clk);
      snap_rdata = resp_rdata; snap_addr = mem_addr; snap_strb = mem_wstrb;
      snap_wdata = mem_wdata;  snap_mis  = misalign;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid = 1'b0; req_we = 1'($urandom_range(0, 1)); req_funct3 = 3'($urandom_range(0, 7));
      req_addr = 16'($urandom); req_wdata = $urandom;
      mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      exp_cycle(1, 0, 0, 0, 0, 0, 16'h0, 4'h0, 32'h0, hold_rdata);
      tick();
   endtask

   // g = cycles of grant delay, r = cycles of rvalid delay, hold keeps req_valid high in DONE
   task automatic run_txn(input logic we, input logic [2:0] f3, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int unsigned g, input int unsigned r, input bit hold,
                          output int unsigned lat);
      bit          mis = is_mis(f3, addr);
      logic [31:0] res = we ? 32'h0 : model_load(f3, addr, rdata);
      lat = 0;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      mem_gnt = 1'b0; mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      exp_cycle(1, 1, 0, 0, 0, 0, 16'h0, 4'h0, 32'h0, hold_rdata);
      tick(); lat++;
      if (!mis) begin
         for (int unsigned i = 0; i <= g; i++) begin
            mem_gnt    = (i == g);
            mem_rvalid = (i < g) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata  = $urandom;
            exp_cycle(0, 1, 0, 0, 1, we, addr & 16'hFFFC,
                      we ? model_strb(f3, addr) : 4'h0,
                      we ? model_wdata(f3, wdata) : 32'h0, hold_rdata);
            tick(); lat++;
         end
         g_addr = snap_addr; g_strb = snap_strb; g_wdata = snap_wdata;
         if (!we) begin
            for (int unsigned i = 0; i <= r; i++) begin
               mem_gnt    = 1'b0;
               mem_rvalid = (i == r);
               mem_rdata  = (i == r) ? rdata : $urandom;
               exp_cycle(0, 1, 0, 0, 0, 0, 16'h0, 4'h0, 32'h0, hold_rdata);
               tick(); lat++;
            end
         end
      end
      req_valid = hold;
      mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      hold_rdata = mis ? 32'h0 : res;
      exp_cycle(0, 0, 1, mis, 0, 0, 16'h0, 4'h0, 32'h0, hold_rdata);
      tick();
      g_rdata = snap_rdata; g_mis = snap_mis;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
      $fatal(1);
   end

   initial begin
      int unsigned lat;
      int          base;
      logic [3:0]  strb1;
      logic        we;
      logic [2:0]  f3;

      // reset values, with req_valid high to show stall is held low
      req_valid = 1'b1;
      #1 reset = 1'b1;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_misalign", 32'(misalign), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      req_valid = 1'b0;
      chk_en = 1'b1;
      idle();

      // LB, signed byte at offset 3
      run_txn(1'b0, 3'b000, 16'h0013, 32'h0, 32'h80FF_1234, 0, 0, 1'b0, lat);
      chk("lb_rdata", g_rdata, 32'hFFFF_FF80);
      chk("lb_latency", lat, 32'd3);
      idle();

      // LHU, upper half
      run_txn(1'b0, 3'b101, 16'h0022, 32'h0, 32'h9ABC_5678, 1, 1, 1'b0, lat);
      chk("lhu_rdata", g_rdata, 32'h0000_9ABC);
      chk("lhu_latency", lat, 32'd5);
      idle();

      // SH, grant delayed two cycles
      run_txn(1'b1, 3'b001, 16'h0042, 32'h1234_BEEF, 32'h0, 2, 0, 1'b0, lat);
      chk("sh_mem_addr", 32'(g_addr), 32'h0040);
      chk("sh_mem_wstrb", 32'(g_strb), 32'hC);
      chk("sh_mem_wdata", g_wdata, 32'hBEEF_BEEF);
      chk("sh_latency", lat, 32'd4);
      chk("sh_rdata", g_rdata, 32'h0);
      idle();

      // LW at a non-word address
      base = req_cycles;
      run_txn(1'b0, 3'b010, 16'h0006, 32'h0, 32'hCAFE_0001, 0, 0, 1'b0, lat);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("lw_mis_flag", 32'(g_mis), 32'd1);
      chk("lw_mis_latency", lat, 32'd1);
      chk("lw_mis_rdata", g_rdata, 32'h0);
      chk("lw_mis_no_req", 32'(req_cycles - base), 32'd0);
`else
      chk("lw_trunc_addr", 32'(g_addr), 32'h0004);
      chk("lw_trunc_rdata", g_rdata, 32'hCAFE_0001);
      chk("lw_trunc_latency", lat, 32'd3);
      chk("lw_trunc_flag", 32'(g_mis), 32'd0);
`endif
      idle();

      // back-to-back SB with req_valid held through both DONE cycles
      base = req_cycles;
      run_txn(1'b1, 3'b000, 16'h0001, $urandom, 32'h0, 0, 0, 1'b1, lat);
      strb1 = g_strb;
      run_txn(1'b1, 3'b000, 16'h0003, $urandom, 32'h0, 0, 0, 1'b1, lat);
      idle();
      chk("b2b_strb_first", 32'(strb1), 32'h2);
      chk("b2b_strb_second", 32'(g_strb), 32'h8);
      chk("b2b_req_count", 32'(req_cycles - base), 32'd2);

      // reset asserted while waiting for load data
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 16'h0010;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      exp_cycle(1, 1, 0, 0, 0, 0, 16'h0, 4'h0, 32'h0, hold_rdata);
      tick();
      mem_gnt = 1'b1;
      exp_cycle(0, 1, 0, 0, 1, 0, 16'h0010, 4'h0, 32'h0, hold_rdata);
      tick();
      mem_gnt = 1'b0;
      chk_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("wait_rst_req_ready", 32'(req_ready), 32'd1);
      chk("wait_rst_stall", 32'(stall), 32'd0);
      chk("wait_rst_mem_req", 32'(mem_req), 32'd0);
      chk("wait_rst_resp_rdata", resp_rdata, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;
      req_valid = 1'b0;
      hold_rdata = 32'h0;
      chk_en = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      exp_cycle(1, 0, 0, 0, 0, 0, 16'h0, 4'h0, 32'h0, hold_rdata);
      tick();
      mem_rvalid = 1'b0;
      exp_cycle(1, 0, 0, 0, 0, 0, 16'h0, 4'h0, 32'h0, hold_rdata);
      tick();

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         we = 1'($urandom_range(0, 1));
         f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
         run_txn(we, f3, 16'($urandom), $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat);
         repeat ($urandom_range(0, 2)) idle();
      end
      idle();

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
